// File: rtl/phys_reg_free_list_pkg.sv
// ============================================================================
// phys_reg_free_list_pkg: shared rename types (tags, ring pointers) | Rev 1.0
// ============================================================================
`default_nettype none

package phys_reg_free_list_pkg;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int PTAG_W   = $clog2(NUM_PHYS);
  localparam int RING_D   = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W    = $clog2(RING_D);

  typedef logic [PTAG_W-1:0] ptag_t;

  // Ring pointer: wrap bit distinguishes full from empty when indices match.
  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    logic [IDX_W:0] v;
    v = {p.wrap, p.idx};
    v = v + 1'b1;
    return ptr_t'(v);
  endfunction

  function automatic logic [IDX_W:0] ptr_diff(input ptr_t a, input ptr_t b);
    logic [IDX_W:0] va;
    logic [IDX_W:0] vb;
    va = {a.wrap, a.idx};
    vb = {b.wrap, b.idx};
    return va - vb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phys_reg_free_list_if.sv
// ============================================================================
// phys_reg_free_list_if: rename/commit bundle for the free list | Rev 1.0
// ============================================================================
`default_nettype none

interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic  alloc_req;
  logic  alloc_gnt;
  ptag_t alloc_ptag;
  logic  free_valid;
  ptag_t free_ptag;
  logic  commit_alloc;
  logic  flush;
  ptag_t free_count;
  logic  empty;
  logic  err;

  modport master (
    output alloc_req, free_valid, free_ptag, commit_alloc, flush,
    input  alloc_gnt, alloc_ptag, free_count, empty, err
  );

  modport slave (
    input  alloc_req, free_valid, free_ptag, commit_alloc, flush,
    output alloc_gnt, alloc_ptag, free_count, empty, err
  );

endinterface

`default_nettype wire

// File: rtl/phys_reg_free_list.sv
// ============================================================================
// phys_reg_free_list: circular free physical-tag allocator with flush rollback
// Rev 1.0
// ============================================================================
`default_nettype none

module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  phys_reg_free_list_if.slave    bus
);

  localparam logic [IDX_W:0] c_ring_full = (IDX_W+1)'(RING_D);
  localparam ptr_t           c_tail_rst  = '{wrap: 1'b1, idx: '0};

  ptag_t          r_ring [RING_D];
  ptr_t           r_spec_head;
  ptr_t           r_commit_head;
  ptr_t           r_tail;
  logic           r_err;

  logic [IDX_W:0] w_free_count;
  logic [IDX_W:0] w_occupancy;
  logic           w_empty;
  logic           w_gnt;
  logic           w_commit_err;
  logic           w_commit_ok;
  logic           w_free_err;
  logic           w_free_ok;
  ptr_t           w_commit_next;

  assign w_free_count = ptr_diff(r_tail, r_spec_head);
  assign w_occupancy  = ptr_diff(r_tail, r_commit_head);
  assign w_empty      = (w_free_count == '0);
  assign w_gnt        = bus.alloc_req & ~w_empty & ~bus.flush;

  // A commit in the same cycle as a grant retires that fresh allocation, so
  // it is only illegal when nothing is outstanding and nothing is granted.
  assign w_commit_err = bus.commit_alloc & (r_commit_head == r_spec_head) & ~w_gnt;
  assign w_commit_ok  = bus.commit_alloc & ~w_commit_err;

  // A same-cycle commit frees one slot, so the release still fits.
  assign w_free_err   = bus.free_valid & (w_occupancy == c_ring_full) & ~w_commit_ok;
  assign w_free_ok    = bus.free_valid & ~w_free_err;

  assign w_commit_next = w_commit_ok ? ptr_inc(r_commit_head) : r_commit_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RING_D; i++) begin
        r_ring[i] <= ptag_t'(NUM_ARCH + i);
      end
    end else if (w_free_ok) begin
      r_ring[r_tail.idx] <= bus.free_ptag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= c_tail_rst;
      r_err         <= 1'b0;
    end else begin
      // Flush rewinds to the committed head; ring contents are left intact.
      if (bus.flush) begin
        r_spec_head <= w_commit_next;
      end else if (w_gnt) begin
        r_spec_head <= ptr_inc(r_spec_head);
      end
      r_commit_head <= w_commit_next;
      if (w_free_ok) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_commit_err || w_free_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.alloc_gnt  = w_gnt;
  assign bus.alloc_ptag = r_ring[r_spec_head.idx];
  assign bus.free_count = w_free_count;
  assign bus.empty      = w_empty;
  assign bus.err        = r_err;

`ifndef SYNTHESIS
  a_no_gnt_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.alloc_gnt && w_empty));

  a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
    w_occupancy <= c_ring_full);
`endif

endmodule

`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
// ============================================================================
// tb_phys_reg_free_list: queue-model scoreboard for the physical tag free list
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic clk;
  logic rst_n;

  phys_reg_free_list_if bus ();

  phys_reg_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       gnt;
    logic [5:0] ptag;
    logic [5:0] cnt;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: free tags in grant order, and granted-but-uncommitted tags.
  int   free_q[$];
  int   infl_q[$];
  logic m_err;

  int total;
  int bad;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.alloc_req    = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_ptag    = '0;
    bus.commit_alloc = 1'b0;
    bus.flush        = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle of stimulus: push the expected response, then advance the model.
  task automatic drive(input logic req, input logic fv, input int ftag,
                       input logic com, input logic fl);
    exp_t e;
    int   nf;
    int   ni;
    bit   gnt;
    bit   cerr;
    bit   cok;
    bit   ferr;
    bus.alloc_req    = req;
    bus.free_valid   = fv;
    bus.free_ptag    = 6'(ftag);
    bus.commit_alloc = com;
    bus.flush        = fl;
    nf      = free_q.size();
    ni      = infl_q.size();
    gnt     = req && (nf > 0) && !fl;
    e.gnt   = gnt;
    e.ptag  = (nf > 0) ? 6'(free_q[0]) : 6'd0;
    e.cnt   = 6'(nf);
    e.empty = (nf == 0);
    e.err   = m_err;
    exp_q.push_back(e);
    cerr = com && (ni == 0) && !gnt;
    cok  = com && !cerr;
    ferr = fv && ((nf + ni) == 32) && !cok;
    if (gnt) infl_q.push_back(free_q.pop_front());
    if (cok) void'(infl_q.pop_front());
    if (fl) begin
      free_q = {infl_q, free_q};
      infl_q.delete();
    end
    if (fv && !ferr) free_q.push_back(ftag);
    if (cerr || ferr) m_err = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("alloc_gnt",  int'(bus.alloc_gnt),  int'(e.gnt));
      chk("free_count", int'(bus.free_count), int'(e.cnt));
      chk("empty",      int'(bus.empty),      int'(e.empty));
      chk("err",        int'(bus.err),        int'(e.err));
      if (!e.empty) chk("alloc_ptag", int'(bus.alloc_ptag), int'(e.ptag));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    model_reset();
    do_reset();

    // Reset drain, then release/reuse from empty.
    repeat (33) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 1, 5, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Flush rollback with a committed head of one.
    do_reset();
    repeat (4) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Alloc, release and commit together; tag 7 follows tag 63.
    do_reset();
    drive(1, 1, 7, 1, 0);
    repeat (33) drive(1, 0, 0, 0, 0);

    // Errors: commit with nothing outstanding, then release into a full ring.
    do_reset();
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    do_reset();
    drive(0, 1, 9, 0, 0);
    repeat (34) drive(1, 0, 0, 0, 0);

    // Reset in the middle of operation.
    do_reset();
    repeat (10) drive(1, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Random traffic; the last round also allows illegal commits/releases.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int n = 0; n < 800; n++) begin
        logic req;
        logic fv;
        logic com;
        logic fl;
        req = ($urandom_range(0, 9) < 7);
        fl  = ($urandom_range(0, 19) == 0);
        com = ($urandom_range(0, 2) == 0);
        fv  = ($urandom_range(0, 2) == 0);
        if (r != 3) begin
          com = com && (infl_q.size() > 0);
          fv  = fv && ((free_q.size() + infl_q.size()) < 32);
        end
        drive(req, fv, int'($urandom_range(0, 63)), com, fl);
      end
    end

    drive(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Allocator for the 64-entry physical register file used by the out-of-order rename stage. It holds free physical tags in a circular ring and hands one out per cycle to the renamer. It takes back tags released by ROB commit, and rolls back speculative allocations on a pipeline flush. It sits between decode/rename, which consumes `alloc_*`, and the ROB commit port, which drives `free_*`, `commit_alloc` and `flush`.

## Interface
- `NUM_PHYS`, 64: physical registers.
- `NUM_ARCH`, 32: architectural registers. At reset, physical tags 0..31 are the identity map.
- `PTAG_W`, 6: physical tag width, `$clog2(NUM_PHYS)`.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `alloc_req`  in  1: renamer needs a destination tag this cycle (decode valid & uses_rw).
- `alloc_gnt`  out  1: tag granted. Renamer may only update its map when this is high.
- `alloc_ptag`  out  PTAG_W: tag being granted. Valid whenever `empty`=0.
- `free_valid`  in  1: commit is releasing the previous mapping of its rw.
- `free_ptag`  in  PTAG_W: tag being released.
- `commit_alloc`  in  1: a committing instruction had allocated a tag. Advances the committed head.
- `flush`  in  1: mispredict/exception recovery. Discards all uncommitted allocations.
- `free_count`  out  PTAG_W: free tags currently available to allocate.
- `empty`  out  1: `free_count`==0. Renamer must stall.
- `err`  out  1: sticky protocol error.

## Operation
- Ring depth D = NUM_PHYS-NUM_ARCH = 32. Pointers are 6 bits: 5 index bits plus 1 wrap bit.
- `spec_head`: next tag to allocate.
- `commit_head`: oldest allocation not yet committed.
- `tail`: next slot to write.
- `free_count` = tail - spec_head.
- Occupancy = tail - commit_head, never more than D.
- Reset values:
  - ring[i] = NUM_ARCH+i; spec_head = commit_head = 0; tail = 32 (wrap bit set).
  - free_count=32, empty=0, err=0, alloc_gnt=0, alloc_ptag=32.
- Allocate:
  - alloc_gnt = alloc_req & !empty & !flush.
  - On grant, spec_head++.
  - alloc_ptag = ring[spec_head[4:0]], driven combinationally.
- Release: when free_valid, ring[tail] <= free_ptag and tail++. Releases are accepted in every cycle, including flush cycles.
- Commit: commit_alloc advances commit_head by one.
- Flush:
  - spec_head <= commit_head, plus 1 if commit_alloc is also high that cycle.
  - Every tag between the committed head and the speculative head becomes free again without being rewritten.
- Simultaneous events:
  - Alloc, release and commit may all occur in the same cycle. Each pointer updates independently.
  - No bypass: a tag released while empty=1 is not grantable until the next cycle.
- `err` is set, and stays set until reset, on any of:
  - free_valid when occupancy==D (overflow). The write is dropped.
  - commit_alloc when commit_head==spec_head.
- Reset mid-operation returns the block to the reset state regardless of outstanding allocations. The renamer and ROB reset in the same cycle.

## Timing
- Grant is zero-latency: `alloc_ptag` and `alloc_gnt` are valid in the same cycle as `alloc_req`.
- Pointer and ring updates take effect at the next posedge.
- `free_count` and `empty` are combinational from registered pointers, so they reflect the previous edge's updates.
- Flush cycle: alloc_gnt=0. The next cycle grants from the restored head.
- Maximum throughput is 1 allocation and 1 release per cycle.
- Wrap-around: the index uses the low 5 bits. The full/empty distinction comes from the wrap bit only.

## Structure
- Shared `cpu_pkg` holds:
  - `NUM_PHYS`, `NUM_ARCH`, and `ptag_t` (`logic [PTAG_W-1:0]`).
  - `ptr_t` (wrap+index), also used by the rename map and ROB.
- Single module, no sub-module. The ring is a flop array: 32x6 bits, 1 read port, 1 write port.
- Add SVA, bound in verification only:
  - no grant while empty;
  - occupancy never exceeds D.

## Test plan
- **Reset drain:** reset, then alloc_req held 33 cycles. Required response:
  - grants 32..63 in order;
  - cycle 33 has empty=1, gnt=0, free_count=0.
- **Release/reuse:** from empty, free_valid with tag 5. Required response:
  - that same cycle gnt=0;
  - next cycle empty=0, and an alloc grants 5.
- **Flush rollback:** after reset, 4 allocs (tags 32..35), commit_alloc ×1, then flush. Required response:
  - next alloc grants 33;
  - free_count=31.
- **Simultaneous:** same cycle as alloc (tag 32), free_valid with tag 7, and commit_alloc. Required response:
  - free_count stays 32;
  - tag 7 is later granted after tag 63.
- **Errors:** commit_alloc with no allocation outstanding sets err=1. In a separate run, free_valid at occupancy 32 sets err=1 and leaves tail unchanged.
- **Reset mid-op:** allocate 10, assert rst_n=0 for one cycle. Required response: free_count=32, alloc grants 32, err=0.
